// File: rtl/ddr0_wr_arb_if.sv
// rtl/ddr0_wr_arb_if.sv - AXI4 write-channel (AW/W/B) bundle for the ddr0 write arbiter
interface ddr0_wr_arb_if #(
    parameter int ADDR_WIDTH = 42,
    parameter int DATA_WIDTH = 256,
    parameter int WSTRB_W    = DATA_WIDTH / 8,
    parameter int LEN_W      = 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [LEN_W-1:0]      awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [WSTRB_W-1:0]    wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/ddr0_wr_arb.sv
// rtl/ddr0_wr_arb.sv - two-requester burst-granular AXI4 write arbiter for cl_ddr0 (option macro: DDR0_WR_ARB_FIXED_PRIO_EN)
module ddr0_wr_arb #(
    parameter int ADDR_WIDTH = 42,
    parameter int DATA_WIDTH = 256,
    parameter int WSTRB_W    = DATA_WIDTH / 8,
    parameter int LEN_W      = 8
) (
    input  logic          clk,
    input  logic          reset,
    ddr0_wr_arb_if.slave  s0,
    ddr0_wr_arb_if.slave  s1,
    ddr0_wr_arb_if.master m,
    output logic          o_grant,
    output logic          o_busy,
    output logic          o_len_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam logic [LEN_W:0] BEAT_ONE = {{LEN_W{1'b0}}, 1'b1};

    state_t            state;
    logic              rr_last;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W:0]    beat_cnt;

    logic [ADDR_WIDTH-1:0] awaddr_mux;
    logic [LEN_W-1:0]      awlen_mux;
    logic [2:0]            awsize_mux;
    logic [1:0]            awburst_mux;
    logic                  awvalid_mux;
    logic [DATA_WIDTH-1:0] wdata_mux;
    logic [WSTRB_W-1:0]    wstrb_mux;
    logic                  wlast_mux;
    logic                  wvalid_mux;
    logic                  bready_mux;

    logic both_req;
    logic winner;
    logic awvalid_out;
    logic wvalid_out;
    logic bready_out;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic beat_is_last;

    // Select the granted requester's payload and handshake inputs
    always_comb begin
        if (o_grant) begin
            awaddr_mux  = s1.awaddr;
            awlen_mux   = s1.awlen;
            awsize_mux  = s1.awsize;
            awburst_mux = s1.awburst;
            awvalid_mux = s1.awvalid;
            wdata_mux   = s1.wdata;
            wstrb_mux   = s1.wstrb;
            wlast_mux   = s1.wlast;
            wvalid_mux  = s1.wvalid;
            bready_mux  = s1.bready;
        end else begin
            awaddr_mux  = s0.awaddr;
            awlen_mux   = s0.awlen;
            awsize_mux  = s0.awsize;
            awburst_mux = s0.awburst;
            awvalid_mux = s0.awvalid;
            wdata_mux   = s0.wdata;
            wstrb_mux   = s0.wstrb;
            wlast_mux   = s0.wlast;
            wvalid_mux  = s0.wvalid;
            bready_mux  = s0.bready;
        end
    end

    // Pick the next owner: round-robin on a tie, or requester 0 when fixed priority is built in
    always_comb begin
        both_req = s0.awvalid && s1.awvalid;
`ifdef DDR0_WR_ARB_FIXED_PRIO_EN
        winner = both_req ? 1'b0 : s1.awvalid;
`else
        winner = both_req ? ~rr_last : s1.awvalid;
`endif
    end

    // Valids are gated by phase so W can never precede its accepted AW
    assign awvalid_out  = (state == ADDR) && awvalid_mux;
    assign wvalid_out   = (state == DATA) && wvalid_mux;
    assign bready_out   = (state == RESP) && bready_mux;
    assign aw_hs        = awvalid_out && m.awready;
    assign w_hs         = wvalid_out && m.wready;
    assign b_hs         = bready_out && m.bvalid;
    assign beat_is_last = (beat_cnt == {1'b0, len_q});

    assign m.awaddr  = awaddr_mux;
    assign m.awlen   = awlen_mux;
    assign m.awsize  = awsize_mux;
    assign m.awburst = awburst_mux;
    assign m.awvalid = awvalid_out;
    assign m.wdata   = wdata_mux;
    assign m.wstrb   = wstrb_mux;
    assign m.wlast   = wlast_mux;
    assign m.wvalid  = wvalid_out;
    assign m.bready  = bready_out;

    assign s0.awready = (state == ADDR) && !o_grant && m.awready;
    assign s0.wready  = (state == DATA) && !o_grant && m.wready;
    assign s0.bvalid  = (state == RESP) && !o_grant && m.bvalid;
    assign s0.bresp   = ((state == RESP) && !o_grant) ? m.bresp : 2'b00;

    assign s1.awready = (state == ADDR) && o_grant && m.awready;
    assign s1.wready  = (state == DATA) && o_grant && m.wready;
    assign s1.bvalid  = (state == RESP) && o_grant && m.bvalid;
    assign s1.bresp   = ((state == RESP) && o_grant) ? m.bresp : 2'b00;

    assign o_busy = (state != IDLE);

    // Burst FSM: arbitrate, pass AW, count W beats, pass B, then release the grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            o_grant   <= 1'b0;
            rr_last   <= 1'b1;
            len_q     <= '0;
            beat_cnt  <= '0;
            o_len_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0.awvalid || s1.awvalid) begin
                        o_grant <= winner;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        len_q    <= awlen_mux;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        if (beat_cnt != '1) begin
                            beat_cnt <= beat_cnt + BEAT_ONE;
                        end
                        if (wlast_mux != beat_is_last) begin
                            o_len_err <= 1'b1;
                        end
                        if (wlast_mux) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        rr_last <= o_grant;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr0_wr_arb.sv
// tb/tb_ddr0_wr_arb.sv - scoreboard testbench for ddr0_wr_arb
module tb_ddr0_wr_arb;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic o_grant, o_busy, o_len_err;

    ddr0_wr_arb_if s0_if ();
    ddr0_wr_arb_if s1_if ();
    ddr0_wr_arb_if m_if ();

    ddr0_wr_arb dut (
        .clk       (clk),
        .reset     (reset),
        .s0        (s0_if),
        .s1        (s1_if),
        .m         (m_if),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_len_err (o_len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic g; logic [41:0] addr; logic [7:0] len; } aw_t;
    typedef struct packed { logic [255:0] data; logic last; } w_t;

    aw_t        exp_aw[$];
    w_t         exp_w[$];
    logic [1:0] exp_b0[$];
    logic [1:0] exp_b1[$];

    int n_tests = 0;
    int n_fail  = 0;

    int   aw_stall = 0;
    logic wready_toggle = 1'b0;
    int   b_delay = 0;
    logic [1:0] next_bresp = 2'b00;

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // DDR slave model: stall AW, toggle W ready, delay B
    initial begin
        logic w_last_hs, b_hs;
        int   b_wait;
        logic b_pend;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0; m_if.bresp = 2'b00;
        b_wait = 0; b_pend = 1'b0;
        forever begin
            @(negedge clk);
            w_last_hs = m_if.wvalid && m_if.wready && m_if.wlast;
            b_hs      = m_if.bvalid && m_if.bready;
            @(posedge clk);
            #1;
            if (!reset) begin
                m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0; m_if.bresp = 2'b00;
                b_pend = 1'b0;
            end else begin
                if (b_hs) begin m_if.bvalid = 1'b0; m_if.bresp = 2'b00; end
                if (w_last_hs) begin b_pend = 1'b1; b_wait = b_delay; end
                if (b_pend && !m_if.bvalid) begin
                    if (b_wait == 0) begin
                        m_if.bvalid = 1'b1; m_if.bresp = next_bresp; b_pend = 1'b0;
                    end else begin
                        b_wait--;
                    end
                end
                if (aw_stall > 0 && m_if.awvalid) aw_stall--;
                m_if.awready = (aw_stall == 0);
                m_if.wready  = wready_toggle ? ~m_if.wready : 1'b1;
            end
        end
    end

    // Monitor: pop expected transfers on every handshake, check isolation and ordering
    initial begin
        logic aw_out;
        aw_t  ea;
        w_t   ew;
        aw_out = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                aw_out = 1'b0;
            end else begin
                if (m_if.awvalid && m_if.awready) begin
                    if (exp_aw.size() == 0) fail("aw_unexpected");
                    else begin
                        ea = exp_aw.pop_front();
                        chk("aw_grant", 256'(o_grant), 256'(ea.g));
                        chk("aw_addr", 256'(m_if.awaddr), 256'(ea.addr));
                        chk("aw_len", 256'(m_if.awlen), 256'(ea.len));
                    end
                    aw_out = 1'b1;
                end
                if (m_if.wvalid) chk("w_after_aw", 256'(aw_out), 256'(1));
                if (m_if.wvalid && m_if.wready) begin
                    if (exp_w.size() == 0) fail("w_unexpected");
                    else begin
                        ew = exp_w.pop_front();
                        chk("w_data", m_if.wdata, ew.data);
                        chk("w_last", 256'(m_if.wlast), 256'(ew.last));
                    end
                end
                if (m_if.bvalid && m_if.bready) aw_out = 1'b0;
                if (s0_if.bvalid && s0_if.bready) begin
                    if (exp_b0.size() == 0) fail("b0_unexpected");
                    else chk("b0_resp", 256'(s0_if.bresp), 256'(exp_b0.pop_front()));
                end
                if (s1_if.bvalid && s1_if.bready) begin
                    if (exp_b1.size() == 0) fail("b1_unexpected");
                    else chk("b1_resp", 256'(s1_if.bresp), 256'(exp_b1.pop_front()));
                end
                if (o_grant)
                    chk("s0_isolated", 256'({s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.bresp}), 256'(0));
                else
                    chk("s1_isolated", 256'({s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.bresp}), 256'(0));
            end
        end
    end

    task automatic drive_aw(int r, logic v, logic [41:0] a, logic [7:0] l);
        if (r == 0) begin
            s0_if.awvalid = v; s0_if.awaddr = a; s0_if.awlen = l; s0_if.awsize = 3'd5; s0_if.awburst = 2'b01;
        end else begin
            s1_if.awvalid = v; s1_if.awaddr = a; s1_if.awlen = l; s1_if.awsize = 3'd5; s1_if.awburst = 2'b01;
        end
    endtask

    task automatic drive_w(int r, logic v, logic [255:0] d, logic last);
        if (r == 0) begin
            s0_if.wvalid = v; s0_if.wdata = d; s0_if.wlast = last; s0_if.wstrb = '1;
        end else begin
            s1_if.wvalid = v; s1_if.wdata = d; s1_if.wlast = last; s1_if.wstrb = '1;
        end
    endtask

    task automatic drive_bready(int r, logic v);
        if (r == 0) s0_if.bready = v;
        else s1_if.bready = v;
    endtask

    function automatic logic ev(int k);
        case (k)
            0: return s0_if.awready;
            1: return s1_if.awready;
            2: return s0_if.wready;
            3: return s1_if.wready;
            4: return s0_if.bvalid;
            5: return s1_if.bvalid;
            default: return m_if.wvalid && m_if.wready && m_if.wlast;
        endcase
    endfunction

    task automatic wait_ev(int k, string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (ev(k)) break;
            n++;
            if (n > 300) begin fail(name); break; end
        end
    endtask

    task automatic expect_burst(int r, logic [41:0] a, logic [7:0] l, logic [255:0] base, int nb, logic [1:0] resp);
        exp_aw.push_back('{g: 1'(r), addr: a, len: l});
        for (int i = 0; i < nb; i++) exp_w.push_back('{data: base + 256'(i), last: (i == nb - 1)});
        if (r == 0) exp_b0.push_back(resp);
        else exp_b1.push_back(resp);
    endtask

    // Requester driver; entered and left just after a rising edge
    task automatic drive_burst(int r, logic [41:0] a, logic [7:0] l, logic [255:0] base, int nb);
        drive_aw(r, 1'b1, a, l);
        wait_ev(r, "aw_timeout");
        @(posedge clk); #1;
        drive_aw(r, 1'b0, '0, '0);
        for (int i = 0; i < nb; i++) begin
            drive_w(r, 1'b1, base + 256'(i), (i == nb - 1));
            wait_ev(2 + r, "w_timeout");
            @(posedge clk); #1;
        end
        drive_w(r, 1'b0, '0, 1'b0);
        drive_bready(r, 1'b1);
        wait_ev(4 + r, "b_timeout");
        @(posedge clk); #1;
        drive_bready(r, 1'b0);
    endtask

    task automatic clear_inputs();
        drive_aw(0, 1'b0, '0, '0); drive_aw(1, 1'b0, '0, '0);
        drive_w(0, 1'b0, '0, 1'b0); drive_w(1, 1'b0, '0, 1'b0);
        drive_bready(0, 1'b0); drive_bready(1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pair(logic first);
        expect_burst(int'(first), 42'h100 + 42'(first), 8'd0, 256'hA0 + 256'(first), 1, 2'b00);
        expect_burst(int'(!first), 42'h100 + 42'(!first), 8'd0, 256'hA0 + 256'(!first), 1, 2'b00);
        fork
            drive_burst(0, 42'h100, 8'd0, 256'hA0, 1);
            drive_burst(1, 42'h101, 8'd0, 256'hA1, 1);
        join
    endtask

    initial begin
        #200000;
        fail("watchdog");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 256'(o_grant), 256'(0));
        chk("rst_busy", 256'(o_busy), 256'(0));
        chk("rst_len_err", 256'(o_len_err), 256'(0));
        chk("rst_valids", 256'({m_if.awvalid, m_if.wvalid, m_if.bready}), 256'(0));
        chk("rst_s_ready", 256'({s0_if.awready, s0_if.wready, s0_if.bvalid, s1_if.awready, s1_if.wready, s1_if.bvalid}), 256'(0));
        do_reset();

        // Single s0 burst, arbitration latency
        expect_burst(0, 42'h3500_0000, 8'd3, 256'h10, 4, 2'b00);
        fork
            drive_burst(0, 42'h3500_0000, 8'd3, 256'h10, 4);
            begin
                @(negedge clk); chk("aw_lat_idle", 256'(m_if.awvalid), 256'(0));
                @(negedge clk); chk("aw_lat_addr", 256'(m_if.awvalid), 256'(1));
            end
        join
        chk("single_len_err", 256'(o_len_err), 256'(0));

        // Simultaneous requests from reset, twice, then a tie after a lone s0 burst
        do_reset();
        pair(1'b0);
        pair(1'b0);
        expect_burst(0, 42'h200, 8'd0, 256'hB0, 1, 2'b00);
        drive_burst(0, 42'h200, 8'd0, 256'hB0, 1);
`ifdef DDR0_WR_ARB_FIXED_PRIO_EN
        pair(1'b0);
`else
        pair(1'b1);
`endif

        // Backpressure on all three channels
        aw_stall = 6; wready_toggle = 1'b1; b_delay = 10; next_bresp = 2'b01;
        expect_burst(0, 42'h3600_0000, 8'd3, 256'h1, 4, 2'b01);
        fork
            drive_burst(0, 42'h3600_0000, 8'd3, 256'h1, 4);
            begin
                int   n;
                logic dropped;
                n = 0; dropped = 1'b0;
                @(negedge clk);
                do begin
                    @(negedge clk);
                    if (!o_busy) dropped = 1'b1;
                    n++;
                end while (!(s0_if.bvalid && s0_if.bready) && n < 400);
                chk("bp_busy_held", 256'(dropped), 256'(0));
            end
        join
        aw_stall = 0; wready_toggle = 1'b0; b_delay = 0; next_bresp = 2'b00;

        // Early wlast from s1 sets the sticky length error
        expect_burst(1, 42'h3700_0000, 8'd3, 256'h20, 2, 2'b00);
        drive_burst(1, 42'h3700_0000, 8'd3, 256'h20, 2);
        chk("len_err_set", 256'(o_len_err), 256'(1));
        expect_burst(0, 42'h3700_1000, 8'd1, 256'h30, 2, 2'b00);
        drive_burst(0, 42'h3700_1000, 8'd1, 256'h30, 2);
        chk("len_err_sticky", 256'(o_len_err), 256'(1));

        // s1 request arriving while s0 waits for its response
        b_delay = 4;
        expect_burst(0, 42'h400, 8'd1, 256'h100, 2, 2'b00);
        expect_burst(1, 42'h500, 8'd0, 256'h200, 1, 2'b00);
        fork
            drive_burst(0, 42'h400, 8'd1, 256'h100, 2);
            begin
                wait_ev(6, "cont_wlast_timeout");
                @(posedge clk); #1;
                fork
                    drive_burst(1, 42'h500, 8'd0, 256'h200, 1);
                    begin
                        wait_ev(4, "cont_b0_timeout");
                        @(negedge clk); chk("cont_idle", 256'(o_busy), 256'(0));
                        @(negedge clk);
                        chk("cont_grant", 256'(o_grant), 256'(1));
                        chk("cont_awvalid", 256'(m_if.awvalid), 256'(1));
                    end
                join
            end
        join
        b_delay = 0;

        // Reset asserted in the middle of an 8-beat s1 burst
        exp_aw.push_back('{g: 1'b1, addr: 42'h77_0000, len: 8'd7});
        exp_w.push_back('{data: 256'h301, last: 1'b0});
        exp_w.push_back('{data: 256'h302, last: 1'b0});
        drive_aw(1, 1'b1, 42'h77_0000, 8'd7);
        wait_ev(1, "rst_aw_timeout");
        @(posedge clk); #1;
        drive_aw(1, 1'b0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            drive_w(1, 1'b1, 256'h301 + 256'(i), 1'b0);
            wait_ev(3, "rst_w_timeout");
            @(posedge clk); #1;
        end
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", 256'(o_busy), 256'(0));
        chk("mid_rst_grant", 256'(o_grant), 256'(0));
        chk("mid_rst_len_err", 256'(o_len_err), 256'(0));
        chk("mid_rst_valids", 256'({m_if.awvalid, m_if.wvalid, m_if.bready}), 256'(0));
        chk("mid_rst_s1", 256'({s1_if.awready, s1_if.wready, s1_if.bvalid}), 256'(0));
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        next_bresp = 2'b10;
        expect_burst(1, 42'h78_0000, 8'd1, 256'h400, 2, 2'b10);
        drive_burst(1, 42'h78_0000, 8'd1, 256'h400, 2);
        chk("post_rst_len_err", 256'(o_len_err), 256'(0));

        repeat (3) @(posedge clk);
        chk("sb_aw_empty", 256'(exp_aw.size()), 256'(0));
        chk("sb_w_empty", 256'(exp_w.size()), 256'(0));
        chk("sb_b_empty", 256'(exp_b0.size() + exp_b1.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
